// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbitration stage.
// Writeback payload layout and the per-cycle writeback port count live here,
// so that the regfile and ROB size their write ports from the same constant.
package wb_arbiter_pkg;

    localparam int ROB_IDX_W  = 6;
    localparam int IROB_IDX_W = 4;
    localparam int IPRD_IDX_W = 7;
    localparam int XLEN       = 64;

    // Number of writeback ports per cycle (regfile write ports, ROB completion ports)
    localparam int WB_PORT_NUM = 2;

    typedef logic [IPRD_IDX_W-1:0] iprIdx_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0]  rob_idx;
        logic [IROB_IDX_W-1:0] irob_idx;
        logic                  use_imm;
        logic                  rd_wen;
        iprIdx_t               iprd_idx;
        logic [XLEN-1:0]       result;
    } comwbInfo_t;

    // Round-robin pointer width: ceil(log2(n)), never less than one bit
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of FU completion inputs and writeback outputs of the arbiter.
// master: the FU / consumer side; slave: the arbiter itself.
interface wb_arbiter_if import wb_arbiter_pkg::*; #(
    parameter int NUM_FU     = 4,
    parameter int NUM_WBPORT = WB_PORT_NUM,
    parameter int CNT_W      = 32
);

    logic [NUM_FU-1:0]                 i_fu_finished;
    comwbInfo_t [NUM_FU-1:0]           i_comwbInfo;
    logic [NUM_FU-1:0]                 o_wb_stall;
    logic [NUM_WBPORT-1:0]             o_wb_vld;
    comwbInfo_t [NUM_WBPORT-1:0]       o_wb_info;
    logic [NUM_WBPORT-1:0]             o_rf_wen;
    logic [CNT_W-1:0]                  o_conflict_cnt;

    modport master (
        output i_fu_finished,
        output i_comwbInfo,
        input  o_wb_stall,
        input  o_wb_vld,
        input  o_wb_info,
        input  o_rf_wen,
        input  o_conflict_cnt
    );

    modport slave (
        input  i_fu_finished,
        input  i_comwbInfo,
        output o_wb_stall,
        output o_wb_vld,
        output o_wb_info,
        output o_rf_wen,
        output o_conflict_cnt
    );

endinterface

// File: rtl/wb_arbiter_rr_multi_grant.sv
// Combinational round-robin multi-grant selector.
// Scans requesters starting at ptr (wrapping), grants the first NUM_GNT of them
// and maps the k-th grant to output slot k via a one-hot select per slot.
// Also usable as an issue-select stage.
module rr_multi_grant import wb_arbiter_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int NUM_GNT = 2,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]              req,
    input  logic [PTR_W-1:0]                ptr,
    output logic [NUM_REQ-1:0]              grant,
    output logic [NUM_GNT-1:0][NUM_REQ-1:0] sel
);

    // Walk the requesters in scan order and hand each one the lowest free slot
    always_comb begin
        logic [PTR_W-1:0]   idx_s;
        logic [NUM_GNT-1:0] used_s;
        logic               placed_s;
        grant    = '0;
        sel      = '0;
        used_s   = '0;
        idx_s    = ptr;
        placed_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            placed_s = 1'b0;
            for (int p = 0; p < NUM_GNT; p++) begin
                if (req[idx_s] && !placed_s && !used_s[p]) begin
                    sel[p][idx_s] = 1'b1;
                    grant[idx_s]  = 1'b1;
                    used_s[p]     = 1'b1;
                    placed_s      = 1'b1;
                end else begin
                    placed_s = placed_s;
                end
            end
            // Explicit wrap so non-power-of-two requester counts work
            if (idx_s == PTR_W'(NUM_REQ - 1)) begin
                idx_s = '0;
            end else begin
                idx_s = idx_s + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: takes FU completions, grants up to NUM_WBPORT per cycle
// round-robin, stalls the losers in the same cycle and registers the winners
// onto the writeback ports feeding the regfile and ROB.
module wb_arbiter import wb_arbiter_pkg::*; #(
    parameter int NUM_FU     = 4,
    parameter int NUM_WBPORT = WB_PORT_NUM,
    parameter int CNT_W      = 32
) (
    input  logic       clk,
    input  logic       rst,
    wb_arbiter_if.slave wb
);

    localparam int PTR_W = ptr_width(NUM_FU);

    logic [NUM_FU-1:0]                 req_s;
    logic [NUM_FU-1:0]                 grant_s;
    logic [NUM_WBPORT-1:0][NUM_FU-1:0] sel_s;
    logic [NUM_FU-1:0]                 stall_s;

    logic [PTR_W-1:0]                  rr_ptr_r;
    logic [PTR_W-1:0]                  rr_ptr_nxt_s;
    logic [PTR_W-1:0]                  last_idx_s;

    logic [NUM_WBPORT-1:0]             wb_vld_nxt_s;
    logic [NUM_WBPORT-1:0]             rf_wen_nxt_s;
    comwbInfo_t [NUM_WBPORT-1:0]       wb_info_nxt_s;

    logic [NUM_WBPORT-1:0]             wb_vld_r;
    logic [NUM_WBPORT-1:0]             rf_wen_r;
    comwbInfo_t [NUM_WBPORT-1:0]       wb_info_r;
    logic [CNT_W-1:0]                  conflict_cnt_r;

    assign req_s = wb.i_fu_finished;

    rr_multi_grant #(
        .NUM_REQ (NUM_FU),
        .NUM_GNT (NUM_WBPORT),
        .PTR_W   (PTR_W)
    ) u_rr_multi_grant (
        .req   (req_s),
        .ptr   (rr_ptr_r),
        .grant (grant_s),
        .sel   (sel_s)
    );

    // Same-cycle back-pressure to requesters that lost; silenced during reset
    always_comb begin
        stall_s = '0;
        if (rst) begin
            stall_s = '0;
        end else begin
            stall_s = req_s & ~grant_s;
        end
    end

    // Route each granted FU payload onto its port; idle ports carry zeros
    always_comb begin
        wb_vld_nxt_s  = '0;
        rf_wen_nxt_s  = '0;
        wb_info_nxt_s = '0;
        for (int p = 0; p < NUM_WBPORT; p++) begin
            wb_vld_nxt_s[p] = |sel_s[p];
            for (int i = 0; i < NUM_FU; i++) begin
                wb_info_nxt_s[p] = wb_info_nxt_s[p]
                                 | (wb.i_comwbInfo[i] & {$bits(comwbInfo_t){sel_s[p][i]}});
            end
            rf_wen_nxt_s[p] = wb_vld_nxt_s[p] & wb_info_nxt_s[p].rd_wen;
        end
    end

    // Next pointer: one past the FU on the highest used port, else hold
    always_comb begin
        last_idx_s   = '0;
        rr_ptr_nxt_s = rr_ptr_r;
        for (int p = 0; p < NUM_WBPORT; p++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                last_idx_s = sel_s[p][i] ? PTR_W'(i) : last_idx_s;
            end
        end
        if (|grant_s) begin
            if (last_idx_s == PTR_W'(NUM_FU - 1)) begin
                rr_ptr_nxt_s = '0;
            end else begin
                rr_ptr_nxt_s = last_idx_s + PTR_W'(1);
            end
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
    end

    // Pointer, writeback port and conflict counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r       <= '0;
            wb_vld_r       <= '0;
            rf_wen_r       <= '0;
            wb_info_r      <= '0;
            conflict_cnt_r <= '0;
        end else begin
            rr_ptr_r  <= rr_ptr_nxt_s;
            wb_vld_r  <= wb_vld_nxt_s;
            rf_wen_r  <= rf_wen_nxt_s;
            wb_info_r <= wb_info_nxt_s;
            if ((|stall_s) && (conflict_cnt_r != {CNT_W{1'b1}})) begin
                conflict_cnt_r <= conflict_cnt_r + CNT_W'(1);
            end else begin
                conflict_cnt_r <= conflict_cnt_r;
            end
        end
    end

    assign wb.o_wb_stall     = stall_s;
    assign wb.o_wb_vld       = wb_vld_r;
    assign wb.o_rf_wen       = rf_wen_r;
    assign wb.o_wb_info      = wb_info_r;
    assign wb.o_conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter (4 FUs, 2 writeback ports).
// A second instance with a 4-bit counter shares the stimulus to exercise
// counter saturation.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NFU = 4;
    localparam int NP  = 2;

    logic clk = 1'b0;
    logic rst;
    logic [NFU-1:0] fin;
    comwbInfo_t [NFU-1:0] info;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.NUM_FU(NFU), .NUM_WBPORT(NP), .CNT_W(32)) bus ();
    wb_arbiter_if #(.NUM_FU(NFU), .NUM_WBPORT(NP), .CNT_W(4))  bus_sat ();

    assign bus.i_fu_finished     = fin;
    assign bus.i_comwbInfo       = info;
    assign bus_sat.i_fu_finished = fin;
    assign bus_sat.i_comwbInfo   = info;

    wb_arbiter #(.NUM_FU(NFU), .NUM_WBPORT(NP), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    wb_arbiter #(.NUM_FU(NFU), .NUM_WBPORT(NP), .CNT_W(4)) dut_sat (
        .clk (clk),
        .rst (rst),
        .wb  (bus_sat)
    );

    function automatic comwbInfo_t mk_info(input logic [5:0] rob, input logic [63:0] res,
                                           input logic wen, input logic [6:0] iprd);
        comwbInfo_t t;
        t          = '0;
        t.rob_idx  = rob;
        t.irob_idx = rob[3:0];
        t.rd_wen   = wen;
        t.iprd_idx = iprd;
        t.result   = res;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        fin  = '0;
        info = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.o_wb_vld !== 2'b00) begin errors++; $display("FAIL reset_vld got %b exp 00", bus.o_wb_vld); end
        checks++; if (bus.o_rf_wen !== 2'b00) begin errors++; $display("FAIL reset_rf_wen got %b exp 00", bus.o_rf_wen); end
        checks++; if (bus.o_wb_info[0].result !== 64'd0) begin errors++; $display("FAIL reset_info got %h exp 0", bus.o_wb_info[0].result); end
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if (bus.o_wb_stall !== 4'b0000) begin errors++; $display("FAIL idle_stall got %b exp 0000", bus.o_wb_stall); end
            tick();
            checks++; if (bus.o_wb_vld !== 2'b00) begin errors++; $display("FAIL idle_vld got %b exp 00", bus.o_wb_vld); end
        end
        checks++; if (bus.o_conflict_cnt !== 32'd0) begin errors++; $display("FAIL idle_cnt got %0d exp 0", bus.o_conflict_cnt); end
        checks++; if (dut.rr_ptr_r !== 2'd0) begin errors++; $display("FAIL idle_ptr got %0d exp 0", dut.rr_ptr_r); end
    endtask

    task automatic test_all_request();
        for (int i = 0; i < NFU; i++) info[i] = mk_info(6'(i + 1), 64'h100 + 64'(i), 1'b1, 7'(10 + i));
        fin = 4'b1111;
        #2;
        checks++; if (bus.o_wb_stall !== 4'b1100) begin errors++; $display("FAIL all_stall0 got %b exp 1100", bus.o_wb_stall); end
        tick();
        checks++; if (bus.o_wb_vld !== 2'b11) begin errors++; $display("FAIL all_vld0 got %b exp 11", bus.o_wb_vld); end
        checks++; if (bus.o_wb_info[0].result !== 64'h100) begin errors++; $display("FAIL all_p0_fu0 got %h exp 100", bus.o_wb_info[0].result); end
        checks++; if (bus.o_wb_info[1].result !== 64'h101) begin errors++; $display("FAIL all_p1_fu1 got %h exp 101", bus.o_wb_info[1].result); end
        checks++; if (dut.rr_ptr_r !== 2'd2) begin errors++; $display("FAIL all_ptr0 got %0d exp 2", dut.rr_ptr_r); end
        fin = 4'b1100;
        #2;
        checks++; if (bus.o_wb_stall !== 4'b0000) begin errors++; $display("FAIL all_stall1 got %b exp 0000", bus.o_wb_stall); end
        tick();
        checks++; if (bus.o_wb_vld !== 2'b11) begin errors++; $display("FAIL all_vld1 got %b exp 11", bus.o_wb_vld); end
        checks++; if (bus.o_wb_info[0].result !== 64'h102) begin errors++; $display("FAIL all_p0_fu2 got %h exp 102", bus.o_wb_info[0].result); end
        checks++; if (bus.o_wb_info[1].result !== 64'h103) begin errors++; $display("FAIL all_p1_fu3 got %h exp 103", bus.o_wb_info[1].result); end
        checks++; if (bus.o_wb_info[1].iprd_idx !== 7'd13) begin errors++; $display("FAIL all_p1_iprd got %0d exp 13", bus.o_wb_info[1].iprd_idx); end
        checks++; if (bus.o_conflict_cnt !== 32'd1) begin errors++; $display("FAIL all_cnt got %0d exp 1", bus.o_conflict_cnt); end
        checks++; if (dut.rr_ptr_r !== 2'd0) begin errors++; $display("FAIL all_ptr1 got %0d exp 0", dut.rr_ptr_r); end
        fin = 4'b0000;
        tick();
        checks++; if (bus.o_wb_vld !== 2'b00) begin errors++; $display("FAIL all_drain got %b exp 00", bus.o_wb_vld); end
    endtask

    task automatic test_single();
        info[1] = mk_info(6'd7, 64'hDEAD, 1'b1, 7'd5);
        fin = 4'b0010;
        #2;
        checks++; if (bus.o_wb_stall !== 4'b0000) begin errors++; $display("FAIL single_stall got %b exp 0000", bus.o_wb_stall); end
        tick();
        fin = 4'b0000;
        checks++; if (bus.o_wb_vld !== 2'b01) begin errors++; $display("FAIL single_vld got %b exp 01", bus.o_wb_vld); end
        checks++; if (bus.o_wb_info[0].result !== 64'hDEAD) begin errors++; $display("FAIL single_result got %h exp dead", bus.o_wb_info[0].result); end
        checks++; if (bus.o_rf_wen !== 2'b01) begin errors++; $display("FAIL single_rf_wen got %b exp 01", bus.o_rf_wen); end
        checks++; if (bus.o_wb_info[0].iprd_idx !== 7'd5) begin errors++; $display("FAIL single_iprd got %0d exp 5", bus.o_wb_info[0].iprd_idx); end
        checks++; if (dut.rr_ptr_r !== 2'd2) begin errors++; $display("FAIL single_ptr got %0d exp 2", dut.rr_ptr_r); end
    endtask

    task automatic test_fairness();
        int gcnt [NFU];
        logic [NFU-1:0] prev_stall;
        for (int i = 0; i < NFU; i++) begin
            info[i] = mk_info(6'(i), 64'(i), 1'b1, 7'(i));
            gcnt[i] = 0;
        end
        prev_stall = '0;
        for (int c = 0; c < 8; c++) begin
            fin = 4'b1111;
            #2;
            checks++; if ((prev_stall & bus.o_wb_stall) !== 4'b0000) begin errors++; $display("FAIL fair_consec cyc %0d got %b prev %b exp no overlap", c, bus.o_wb_stall, prev_stall); end
            prev_stall = bus.o_wb_stall;
            tick();
            for (int p = 0; p < NP; p++) begin
                if (bus.o_wb_vld[p]) gcnt[bus.o_wb_info[p].result[1:0]]++;
            end
        end
        fin = 4'b0000;
        for (int i = 0; i < NFU; i++) begin
            checks++; if (gcnt[i] !== 4) begin errors++; $display("FAIL fair_grants fu%0d got %0d exp 4", i, gcnt[i]); end
        end
        checks++; if (bus.o_conflict_cnt !== 32'd9) begin errors++; $display("FAIL fair_cnt got %0d exp 9", bus.o_conflict_cnt); end
        checks++; if (dut.rr_ptr_r !== 2'd2) begin errors++; $display("FAIL fair_ptr got %0d exp 2", dut.rr_ptr_r); end
    endtask

    task automatic test_no_rd_wen();
        info[2] = mk_info(6'd3, 64'h55, 1'b0, 7'd9);
        fin = 4'b0100;
        tick();
        fin = 4'b0000;
        checks++; if (bus.o_wb_vld !== 2'b01) begin errors++; $display("FAIL nowen_vld got %b exp 01", bus.o_wb_vld); end
        checks++; if (bus.o_rf_wen !== 2'b00) begin errors++; $display("FAIL nowen_rf_wen got %b exp 00", bus.o_rf_wen); end
        checks++; if (bus.o_wb_info[0].result !== 64'h55) begin errors++; $display("FAIL nowen_result got %h exp 55", bus.o_wb_info[0].result); end
        checks++; if (dut.rr_ptr_r !== 2'd3) begin errors++; $display("FAIL nowen_ptr got %0d exp 3", dut.rr_ptr_r); end
    endtask

    task automatic test_reset_mid();
        // From ptr 3, FU0/FU1 win and FU2 would normally be stalled
        for (int i = 0; i < 3; i++) info[i] = mk_info(6'(i), 64'h200 + 64'(i), 1'b1, 7'(i));
        fin = 4'b0111;
        rst = 1'b1;
        #2;
        checks++; if (bus.o_wb_stall !== 4'b0000) begin errors++; $display("FAIL rstmid_stall got %b exp 0000", bus.o_wb_stall); end
        tick();
        rst = 1'b0;
        fin = 4'b0000;
        checks++; if (bus.o_wb_vld !== 2'b00) begin errors++; $display("FAIL rstmid_vld got %b exp 00", bus.o_wb_vld); end
        checks++; if (bus.o_wb_info[0].result !== 64'd0) begin errors++; $display("FAIL rstmid_info got %h exp 0", bus.o_wb_info[0].result); end
        checks++; if (dut.rr_ptr_r !== 2'd0) begin errors++; $display("FAIL rstmid_ptr got %0d exp 0", dut.rr_ptr_r); end
        checks++; if (bus.o_conflict_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_cnt got %0d exp 0", bus.o_conflict_cnt); end
        tick();
        checks++; if (bus.o_wb_vld !== 2'b00) begin errors++; $display("FAIL rstmid_idle got %b exp 00", bus.o_wb_vld); end
    endtask

    task automatic test_saturation();
        fin = 4'b1111;
        for (int c = 0; c < 20; c++) tick();
        fin = 4'b0000;
        checks++; if (bus_sat.o_conflict_cnt !== 4'hF) begin errors++; $display("FAIL sat_cnt4 got %h exp f", bus_sat.o_conflict_cnt); end
        checks++; if (bus.o_conflict_cnt !== 32'd20) begin errors++; $display("FAIL sat_cnt32 got %0d exp 20", bus.o_conflict_cnt); end
        tick();
        checks++; if (bus_sat.o_conflict_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got %h exp f", bus_sat.o_conflict_cnt); end
        checks++; if (bus.o_wb_vld !== 2'b00) begin errors++; $display("FAIL sat_drain got %b exp 00", bus.o_wb_vld); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_all_request();
        test_single();
        test_fairness();
        test_no_rd_wen();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-arbitration stage directly downstream of the integer FUs (alu and siblings).
- Collects each FU's o_fu_finished / o_comwbInfo and grants up to NUM_WBPORT completions per cycle with round-robin fairness.
- Back-pressures losing FUs through their i_wb_stall input.
- Drives registered writeback ports that feed the physical regfile write and the ROB completion logic.

Parameters:
- NUM_FU, 4, number of FU completion inputs (must be >= 1).
- NUM_WBPORT, 2, number of writeback ports per cycle (1 <= NUM_WBPORT <= NUM_FU).
- CNT_W, 32, width of the conflict performance counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- i_fu_finished  input  NUM_FU  per-FU completion valid; FU holds it and its info stable while stalled
- i_comwbInfo  input  NUM_FU x comwbInfo_t  per-FU result {rob_idx, irob_idx, use_imm, rd_wen, iprd_idx, result}
- o_wb_stall  output  NUM_FU  to FU i_wb_stall; 1 = completion not taken this cycle
- o_wb_vld  output  NUM_WBPORT  writeback port valid
- o_wb_info  output  NUM_WBPORT x comwbInfo_t  writeback payload
- o_rf_wen  output  NUM_WBPORT  o_wb_vld[p] && o_wb_info[p].rd_wen
- o_conflict_cnt  output  CNT_W  saturating count of cycles with at least one stalled requester

Behaviour:
- Reset values (rst high at a clk edge): o_wb_vld=0, o_rf_wen=0, o_wb_info=0, rr_ptr=0, o_conflict_cnt=0.
- While rst is high, o_wb_stall is forced to all-zero combinationally.
- Requesters: req[i] = i_fu_finished[i].
- Scan order: rr_ptr, rr_ptr+1, ..., wrapping mod NUM_FU.
- Grants: the first NUM_WBPORT requesters in scan order are granted. The k-th granted FU (k from 0) maps to port k.
- o_wb_stall[i] = req[i] && !grant[i], combinational, same cycle. An FU whose output is not valid is never stalled.
- Output register: at each clk edge, o_wb_vld[p] <= (port p assigned) and o_wb_info[p] <= the granted FU's info. Unassigned ports get vld=0 and info=0.
- Latency: FU o_fu_finished in cycle N with grant -> o_wb_vld in cycle N+1. A stalled FU retries in N+1 with identical info.
- Pointer update: if any grant, rr_ptr <= (index of last granted FU + 1) mod NUM_FU; otherwise it holds. This ensures any continuously requesting FU is granted within ceil(NUM_FU/NUM_WBPORT) cycles.
- Counter: o_conflict_cnt increments when |o_wb_stall is true, saturating at all-ones. No wrap.
- No requesters: all o_wb_vld go to 0 next cycle and no stall is asserted.
- Requesters <= NUM_WBPORT: all are granted, zero stalls, and port order follows scan order from rr_ptr.
- Simultaneous events: a stalled FU's request and a newly arriving request are treated identically. There are no internal buffers, so no entry can be lost or duplicated.
- Reset mid-operation: all valid outputs drop at the next edge. In-flight grants are discarded; the FUs are reset together with this block.
- rr_ptr width: $clog2(NUM_FU), minimum 1 bit. For NUM_FU not a power of two, the wrap is explicit (idx == NUM_FU-1 -> 0).

Decomposition:
- comwbInfo_t and iprIdx_t stay in the shared core package. No new shared types are required.
- Add WB_PORT_NUM as a package constant so the regfile and ROB size their write ports from it.
- One sub-module: rr_multi_grant (inputs req, ptr; outputs grant vector and per-port one-hot select). It is combinational and reusable for issue-select. The pointer and output registers stay in wb_arbiter.

Test Plan (NUM_FU=4, NUM_WBPORT=2):
- Reset, then all req=0 for 3 cycles -> o_wb_vld=00, o_wb_stall=0000, o_conflict_cnt=0, rr_ptr=0.
- FU1 only, result=64'hDEAD, rd_wen=1, iprd_idx=5 -> next cycle port0 vld=1, result=64'hDEAD, o_rf_wen[0]=1, iprd_idx=5; o_wb_stall=0000.
- All 4 FUs request from rr_ptr=0:
  - cycle N: FU0->port0, FU1->port1, stall=1100, rr_ptr->2.
  - cycle N+1 (FU2, FU3 holding, FU0/FU1 idle): FU2->port0, FU3->port1, stall=0000.
  - o_conflict_cnt=1.
- Persistent requests on FU0 and FU3 plus FU1/FU2 every cycle for 8 cycles -> each FU granted exactly 4 times, no FU stalled 2 consecutive cycles.
- rd_wen=0 result from FU2 -> o_wb_vld=1, o_rf_wen=0 on its port.
- rst asserted in the cycle FU0 and FU1 are granted -> next cycle o_wb_vld=00, o_wb_stall=0000 during rst, rr_ptr=0 afterwards.
- Force o_conflict_cnt near saturation (CNT_W=4 build, 20 conflict cycles) -> holds at 4'hF.
